// File: rtl/cellrv32_cpu_regfile_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// cellrv32_cpu_regfile_wb_ctrl_if
// Bundles every signal between the register-file write-back controller and
// its surroundings: the three write-back requesters, the register file write
// port, the long-latency scoreboard allocation and the decode hazard query.
//
// Modports:
//   master - requesters / control unit / register file side (drives requests,
//            allocations and hazard source addresses; observes readies, the
//            write port, init_done and hazard)
//   slave  - the write-back controller itself
// ---------------------------------------------------------------------------
interface cellrv32_cpu_regfile_wb_ctrl_if #(
  parameter int XLEN = 32
);

  logic            init_done_o;

  logic            req0_valid_i;
  logic [4:0]      req0_rd_i;
  logic [XLEN-1:0] req0_data_i;
  logic            req0_ready_o;

  logic            req1_valid_i;
  logic [4:0]      req1_rd_i;
  logic [XLEN-1:0] req1_data_i;
  logic            req1_ready_o;

  logic            req2_valid_i;
  logic [4:0]      req2_rd_i;
  logic [XLEN-1:0] req2_data_i;
  logic            req2_ready_o;

  logic            rf_we_o;
  logic [4:0]      rf_addr_o;
  logic [XLEN-1:0] rf_wdata_o;

  logic            sb_alloc_i;
  logic [4:0]      sb_alloc_rd_i;

  logic [4:0]      hz_rs1_i;
  logic [4:0]      hz_rs2_i;
  logic            hazard_o;

  modport master (
    input  init_done_o,
    output req0_valid_i, req0_rd_i, req0_data_i,
    input  req0_ready_o,
    output req1_valid_i, req1_rd_i, req1_data_i,
    input  req1_ready_o,
    output req2_valid_i, req2_rd_i, req2_data_i,
    input  req2_ready_o,
    input  rf_we_o, rf_addr_o, rf_wdata_o,
    output sb_alloc_i, sb_alloc_rd_i,
    output hz_rs1_i, hz_rs2_i,
    input  hazard_o
  );

  modport slave (
    output init_done_o,
    input  req0_valid_i, req0_rd_i, req0_data_i,
    output req0_ready_o,
    input  req1_valid_i, req1_rd_i, req1_data_i,
    output req1_ready_o,
    input  req2_valid_i, req2_rd_i, req2_data_i,
    output req2_ready_o,
    output rf_we_o, rf_addr_o, rf_wdata_o,
    input  sb_alloc_i, sb_alloc_rd_i,
    input  hz_rs1_i, hz_rs2_i,
    output hazard_o
  );

endinterface

// File: rtl/cellrv32_cpu_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// cellrv32_cpu_regfile_wb_ctrl
// Write-back controller for the general-purpose register file, which has a
// single write port.  After reset it sweeps zeros into every register (the
// BRAM-mapped file has no reset of its own), then arbitrates write-back
// requests from the pipeline (req0), the load unit (req1) and the
// co-processor (req2) onto the port, one grant per cycle.
//
// Optional feature, macro CELLRV32_RF_SCOREBOARD_EN:
//   defined     - busy bits track long-latency destinations and hazard_o
//                 stalls decode while a source register is still pending
//   not defined - no busy bits; hazard_o only covers the init sweep
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - slave modport of cellrv32_cpu_regfile_wb_ctrl_if (requests,
//            readies, write port, scoreboard allocation, hazard query)
//
// Parameters:
//   XLEN     - data width
//   NUM_REGS - 32, or 16 for RV32E (register index bit 4 is then ignored)
// ---------------------------------------------------------------------------
module cellrv32_cpu_regfile_wb_ctrl #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input logic                           clk_i,
  input logic                           rst_i,
  cellrv32_cpu_regfile_wb_ctrl_if.slave bus
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [4:0] RD_MASK  = (NUM_REGS == 16) ? 5'h0F : 5'h1F;
  localparam logic [5:0] CNT_DONE = 6'(NUM_REGS);

  logic [0:0]      state;
  logic [5:0]      cnt;
  logic            rr_ptr;
  logic            we_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            clr_q;

  logic            run;
  logic            grant0;
  logic            grant1;
  logic            grant2;
  logic [4:0]      rd0;
  logic [4:0]      rd1;
  logic [4:0]      rd2;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  // Register indices are aliased onto the physical file (RV32E drops bit 4).
  assign rd0 = bus.req0_rd_i & RD_MASK;
  assign rd1 = bus.req1_rd_i & RD_MASK;
  assign rd2 = bus.req2_rd_i & RD_MASK;

  // req0 always wins; req1/req2 share the remaining slot round-robin,
  // rr_ptr=0 favouring req1 and rr_ptr=1 favouring req2.
  always_comb begin
    run      = (state == ST_RUN);
    grant0   = run && bus.req0_valid_i;
    grant1   = run && !bus.req0_valid_i && bus.req1_valid_i &&
               (!bus.req2_valid_i || !rr_ptr);
    grant2   = run && !bus.req0_valid_i && bus.req2_valid_i &&
               (!bus.req1_valid_i || rr_ptr);
    sel_rd   = rd0;
    sel_data = bus.req0_data_i;
    if (grant1) begin
      sel_rd   = rd1;
      sel_data = bus.req1_data_i;
    end else if (grant2) begin
      sel_rd   = rd2;
      sel_data = bus.req2_data_i;
    end
  end

  assign bus.req0_ready_o = grant0;
  assign bus.req1_ready_o = grant1;
  assign bus.req2_ready_o = grant2;
  assign bus.init_done_o  = (state == ST_RUN);

  // Sweep and write stage.  Sweep writes leave the register one per cycle;
  // the cycle after the last one (cnt == NUM_REGS) switches to RUN with the
  // port idle.  In RUN the accepted request is registered so the write lands
  // one cycle after acceptance.  Accepted writes to x0 are swallowed, and an
  // idle port keeps its last address/data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_INIT;
      cnt     <= '0;
      rr_ptr  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      clr_q   <= 1'b0;
    end else if (state == ST_INIT) begin
      clr_q <= 1'b0;
      if (cnt == CNT_DONE) begin
        we_q  <= 1'b0;
        state <= ST_RUN;
      end else begin
        we_q    <= 1'b1;
        addr_q  <= cnt[4:0];
        wdata_q <= '0;
        cnt     <= cnt + 6'd1;
      end
    end else begin
      if (grant1 || grant2) begin
        rr_ptr <= grant1;
      end
      if ((grant0 || grant1 || grant2) && (sel_rd != 5'd0)) begin
        we_q    <= 1'b1;
        addr_q  <= sel_rd;
        wdata_q <= sel_data;
        clr_q   <= grant1 || grant2;
      end else begin
        we_q  <= 1'b0;
        clr_q <= 1'b0;
      end
    end
  end

  assign bus.rf_we_o    = we_q;
  assign bus.rf_addr_o  = addr_q;
  assign bus.rf_wdata_o = wdata_q;

`ifdef CELLRV32_RF_SCOREBOARD_EN
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [4:0]          alloc_rd;
  logic [4:0]          rs1;
  logic [4:0]          rs2;

  assign alloc_rd = bus.sb_alloc_rd_i & RD_MASK;
  assign rs1      = bus.hz_rs1_i & RD_MASK;
  assign rs2      = bus.hz_rs2_i & RD_MASK;

  // The clear is applied before the set so that an allocation landing on the
  // same register as a committing load/co-processor write keeps it busy.
  always_comb begin
    busy_next = busy;
    if (we_q && clr_q) begin
      busy_next[addr_q[IDX_W-1:0]] = 1'b0;
    end
    if (bus.sb_alloc_i && (alloc_rd != 5'd0)) begin
      busy_next[alloc_rd[IDX_W-1:0]] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign bus.hazard_o = !bus.init_done_o || busy[rs1[IDX_W-1:0]] ||
                        busy[rs2[IDX_W-1:0]];
`else
  logic unused_sb;
  assign unused_sb = ^{bus.sb_alloc_i, bus.sb_alloc_rd_i, bus.hz_rs1_i,
                       bus.hz_rs2_i, clr_q};

  assign bus.hazard_o = !bus.init_done_o;
`endif

endmodule

// File: doc/cellrv32_cpu_regfile_wb_ctrl.md
Name: cellrv32_cpu_regfile_wb_ctrl

Overview:
- Write-back controller for the CPU general-purpose register file, which has a single multiplexed rd/rs1 write port.
- After reset, sequences a zero-initialisation sweep of every register, because the BRAM-mapped file has no reset.
- Arbitrates write-back requests from three sources onto the single port: main pipeline, memory load unit, and co-processor.
- Tracks long-latency destination registers in a scoreboard and raises a read-hazard stall to the control unit.

Parameters:
- XLEN, 32, data path width.
- NUM_REGS, 32, number of physical registers; only 32 or 16 (RV32E) are legal.

Ports:
- clk_i  in  1  global clock, rising edge
- rst_i  in  1  global reset, asynchronous, active-high
- init_done_o  out  1  register sweep complete
- req0_valid_i / req0_rd_i / req0_data_i  in  1/5/XLEN  pipeline write-back request
- req0_ready_o  out  1  req0 accepted this cycle
- req1_valid_i / req1_rd_i / req1_data_i  in  1/5/XLEN  memory-load write-back request
- req1_ready_o  out  1  req1 accepted this cycle
- req2_valid_i / req2_rd_i / req2_data_i  in  1/5/XLEN  co-processor write-back request
- req2_ready_o  out  1  req2 accepted this cycle
- rf_we_o  out  1  register file write enable
- rf_addr_o  out  5  register file write address
- rf_wdata_o  out  XLEN  register file write data
- sb_alloc_i  in  1  issue of a long-latency op (load or co-processor)
- sb_alloc_rd_i  in  5  destination register of that op
- hz_rs1_i / hz_rs2_i  in  5/5  source addresses of the instruction in decode
- hazard_o  out  1  stall request, combinational

Behaviour:
- Reset (asynchronous, any time, including mid-sweep or mid-write):
  - FSM goes to INIT and the sweep counter goes to 0.
  - rf_we_o, rf_addr_o, rf_wdata_o, init_done_o and all readies go to 0.
  - The scoreboard is cleared.
  - Any pending registered write is dropped.
- FSM states: INIT → RUN. There is no way back to INIT except reset.
- INIT:
  - Each cycle: rf_we_o=1, rf_addr_o=cnt, rf_wdata_o=0, cnt increments.
  - After the cycle with cnt=NUM_REGS-1, the FSM enters RUN.
  - init_done_o is 1 from the first RUN cycle onward.
  - All readies are 0 in INIT.
  - hazard_o is 1 in INIT.
- RUN arbitration (combinational grant, one grant per cycle):
  - req0 has absolute priority.
  - req1 and req2 alternate round-robin via a 1-bit pointer that flips only when one of them is granted.
  - After reset the pointer favours req1.
  - readyN = grantN. A transfer occurs when validN and readyN are both 1.
  - Requesters hold valid, rd and data stable until accepted.
- Write stage:
  - The accepted request is registered, so rf_we_o/rf_addr_o/rf_wdata_o appear exactly 1 cycle after acceptance.
  - rf_we_o is held for one cycle.
  - With no acceptance, rf_we_o=0; rf_addr_o and rf_wdata_o hold their last value.
- rd=0: the request is accepted (ready=1) but rf_we_o stays 0. x0 is written only by the INIT sweep.
- NUM_REGS=16: rd[4], rs[4] and sb_alloc_rd_i[4] are ignored, i.e. aliased onto the 16 entries.
- Scoreboard (NUM_REGS busy bits):
  - sb_alloc_i sets busy[sb_alloc_rd_i]. Writes to x0 are never set.
  - A committed req1/req2 write clears busy[rd] at the end of its rf_we_o cycle.
  - A req0 write does not touch the scoreboard.
  - If an alloc and a clear of the same rd fall in the same cycle, the set wins.
  - An alloc to an already-busy register keeps the bit set.
- hazard_o = !init_done_o | busy[hz_rs1_i] | busy[hz_rs2_i]. busy[0] is always 0.
- Hazard timing:
  - hazard_o drops on the cycle after rf_we_o for the cleared register.
  - A synchronous-read register file therefore returns the new value on the first unstalled read.

Optional Feature:
- Macro: CELLRV32_RF_SCOREBOARD_EN.
- Defined: the scoreboard exists as described above.
- Not defined:
  - No busy bits are implemented and sb_alloc_i/sb_alloc_rd_i are ignored.
  - hazard_o = !init_done_o.
  - The control unit must then serialise long-latency ops itself.

Test Plan:
- Reset, NUM_REGS=32 → 32 consecutive cycles of rf_we_o=1 with addr 0..31 and data 0; init_done_o=1 on cycle 33; hazard_o=0 afterward.
- Assert rst_i during the sweep at cnt=10 → outputs go to 0 immediately; on release the sweep restarts from addr 0.
- req0, req1 and req2 all valid continuously (rd 5/6/7, data A/B/C) → req0 is granted every cycle. Then drop req0 → grants alternate 1,2,1,2; rf writes follow 1 cycle later with the matching rd and data.
- req1 with rd=0 and data 0xDEADBEEF → req1_ready_o=1; rf_we_o stays 0.
- sb_alloc rd=9, then hz_rs1_i=9 → hazard_o=1. req1 write to rd=9 is accepted at T, rf_we_o at T+1 → hazard_o=0 at T+2.
- sb_alloc rd=4 in the same cycle as the committing req2 write to rd=4 → busy[4] stays 1 and hazard_o stays 1 for rs2=4.
